// File: rtl/udma_l2_resp_pkg.sv
// -----------------------------------------------------------------------------
// udma_l2_resp_pkg
// Shared definitions for the uDMA L2 responder:
//   - L2_DATA_WIDTH default data width of the L2 ports
//   - OOB_RDATA     read data returned for out-of-range reads
//   - port_e        identifies the ro / wo port (round-robin pointer type)
//   - l2_decode()   byte address -> {in-range flag, word address}
// -----------------------------------------------------------------------------
package udma_l2_resp_pkg;

  localparam int unsigned L2_DATA_WIDTH     = 32;
  localparam logic [31:0] OOB_RDATA         = 32'hBADA_CCE5;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1C00_0000;

  typedef enum logic {
    PORT_RO = 1'b0,
    PORT_WO = 1'b1
  } port_e;

  typedef struct packed {
    logic        in_range;
    logic [29:0] word_addr;
  } l2_decode_t;

  // The offset wraps modulo 2^32, so addresses below the base land at huge
  // offsets and fall out of range naturally. A bank of 2^30 words or more
  // covers the whole 32-bit space and is always in range.
  function automatic l2_decode_t l2_decode(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned mem_addr_width);
    logic [31:0] off;
    l2_decode_t  dec;
    off           = addr - base;
    dec.word_addr = off[31:2];
    if (mem_addr_width >= 30) begin
      dec.in_range = 1'b1;
    end else begin
      dec.in_range = ((off >> (mem_addr_width + 2)) == 32'd0);
    end
    return dec;
  endfunction

endpackage

// File: rtl/udma_l2_resp_if.sv
// -----------------------------------------------------------------------------
// udma_l2_resp_if
// One uDMA L2 port using the req/gnt/rvalid protocol.
//   req    master->slave  request, held until granted
//   wen    master->slave  1 = read, 0 = write
//   addr   master->slave  byte address
//   be     master->slave  byte enables
//   wdata  master->slave  write data
//   gnt    slave->master  grant (combinational from req)
//   rvalid slave->master  response valid, one per granted transaction
//   rdata  slave->master  read data (0 for write responses)
// -----------------------------------------------------------------------------
interface udma_l2_resp_if
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DW = L2_DATA_WIDTH
) ();

  logic            req;
  logic            wen;
  logic [31:0]     addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, wen, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/udma_l2_resp_pipe.sv
// -----------------------------------------------------------------------------
// udma_l2_resp_pipe
// Per-port response delay line. A grant at cycle T produces rvalid at
// T+LATENCY. Stage 1 holds registered flags (valid, in-range, is-read) and
// selects the SRAM read data, which arrives one cycle after the access; any
// further latency is a chain of LATENCY-1 valid/rdata registers.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid         port granted this cycle
//   i_in_range      granted access hits the SRAM
//   i_is_read       granted access is a read
//   i_mem_rdata     SRAM read data (valid one cycle after the access)
//   o_rvalid        response valid
//   o_rdata         response data (0 for writes)
// -----------------------------------------------------------------------------
module udma_l2_resp_pipe
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned DW      = L2_DATA_WIDTH,
  parameter int unsigned LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic          i_in_range,
  input  logic          i_is_read,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);

  localparam logic [DW-1:0] OOB_FILL = {(DW/32){OOB_RDATA}};

  logic          r_s1_valid;
  logic          r_s1_in_range;
  logic          r_s1_is_read;
  logic [DW-1:0] w_s1_rdata;

  // Flags are qualified with i_valid so idle cycles leave them cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_in_range <= 1'b0;
      r_s1_is_read  <= 1'b0;
    end else begin
      r_s1_valid    <= i_valid;
      r_s1_in_range <= i_valid & i_in_range;
      r_s1_is_read  <= i_valid & i_is_read;
    end
  end

  // Writes and idle slots return zero; out-of-range reads return the marker.
  always_comb begin
    w_s1_rdata = '0;
    if (r_s1_valid && r_s1_is_read) begin
      w_s1_rdata = r_s1_in_range ? i_mem_rdata : OOB_FILL;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_lat1
      assign o_rvalid = r_s1_valid;
      assign o_rdata  = w_s1_rdata;
    end else begin : g_latn
      localparam int unsigned NREG = LATENCY - 1;

      logic          r_valid [NREG];
      logic [DW-1:0] r_rdata [NREG];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid[0] <= 1'b0;
          r_rdata[0] <= '0;
        end else begin
          r_valid[0] <= r_s1_valid;
          r_rdata[0] <= w_s1_rdata;
        end
      end

      for (genvar gi = 1; gi < NREG; gi++) begin : g_stage
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_valid[gi] <= 1'b0;
            r_rdata[gi] <= '0;
          end else begin
            r_valid[gi] <= r_valid[gi-1];
            r_rdata[gi] <= r_rdata[gi-1];
          end
        end
      end

      assign o_rvalid = r_valid[NREG-1];
      assign o_rdata  = r_rdata[NREG-1];
    end
  endgenerate

endmodule

// File: rtl/udma_l2_responder.sv
// -----------------------------------------------------------------------------
// udma_l2_responder
// Memory-side responder for the uDMA L2 read-only (ro) and write-only (wo)
// ports. Arbitrates both ports onto one single-port word SRAM (at most one
// grant per cycle, round-robin on contention), decodes the byte address
// against BASE_ADDR and returns one response per grant after LATENCY cycles.
// Ports:
//   sys_clk_i, sys_rst_ni  clock, asynchronous active-low reset
//   ro, wo                 L2 ports (slave side)
//   mem_req_o, mem_we_o    SRAM access / write strobe
//   mem_addr_o             SRAM word address
//   mem_be_o, mem_wdata_o  SRAM byte enables / write data
//   mem_rdata_i            SRAM read data, one cycle after mem_req_o
//   oob_o                  pulses when an out-of-range access is granted
// -----------------------------------------------------------------------------
module udma_l2_responder
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned L2_DATA_WIDTH  = udma_l2_resp_pkg::L2_DATA_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY        = 1
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_ni,
  udma_l2_resp_if.slave              ro,
  udma_l2_resp_if.slave              wo,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0] mem_be_o,
  output logic [L2_DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [L2_DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                       oob_o
);

  port_e                      r_rr_q;
  port_e                      w_rr_next;
  logic                       w_ro_req;
  logic                       w_wo_req;
  logic                       w_ro_gnt;
  logic                       w_wo_gnt;
  logic                       w_any_gnt;
  logic                       w_sel_wen;
  logic [31:0]                w_sel_addr;
  logic [L2_DATA_WIDTH/8-1:0] w_sel_be;
  logic [L2_DATA_WIDTH-1:0]   w_sel_wdata;
  l2_decode_t                 w_dec;
  logic                       w_mem_req;
  logic                       w_unused;

  // Grants are masked while reset is asserted.
  assign w_ro_req = ro.req & sys_rst_ni;
  assign w_wo_req = wo.req & sys_rst_ni;

  // Round-robin pointer: only a contended grant hands priority over.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      r_rr_q <= PORT_RO;
    end else begin
      r_rr_q <= w_rr_next;
    end
  end

  always_comb begin
    w_ro_gnt  = 1'b0;
    w_wo_gnt  = 1'b0;
    w_rr_next = r_rr_q;
    if (w_ro_req && w_wo_req) begin
      if (r_rr_q == PORT_RO) begin
        w_ro_gnt  = 1'b1;
        w_rr_next = PORT_WO;
      end else begin
        w_wo_gnt  = 1'b1;
        w_rr_next = PORT_RO;
      end
    end else begin
      w_ro_gnt = w_ro_req;
      w_wo_gnt = w_wo_req;
    end
  end

  assign ro.gnt    = w_ro_gnt;
  assign wo.gnt    = w_wo_gnt;
  assign w_any_gnt = w_ro_gnt | w_wo_gnt;

  // Request mux for the winning port.
  assign w_sel_wen   = w_wo_gnt ? wo.wen   : ro.wen;
  assign w_sel_addr  = w_wo_gnt ? wo.addr  : ro.addr;
  assign w_sel_be    = w_wo_gnt ? wo.be    : ro.be;
  assign w_sel_wdata = w_wo_gnt ? wo.wdata : ro.wdata;

  assign w_dec = l2_decode(w_sel_addr, BASE_ADDR, MEM_ADDR_WIDTH);

  // Only the low MEM_ADDR_WIDTH word-address bits reach the SRAM; the upper
  // bits only matter through the in-range flag.
  assign w_unused = ^w_dec.word_addr;

  // Out-of-range accesses never touch the SRAM; the bus is zeroed when idle.
  assign w_mem_req   = w_any_gnt & w_dec.in_range;
  assign mem_req_o   = w_mem_req;
  assign mem_we_o    = w_mem_req & ~w_sel_wen;
  assign mem_addr_o  = w_mem_req ? w_dec.word_addr[MEM_ADDR_WIDTH-1:0] : '0;
  assign mem_be_o    = w_mem_req ? w_sel_be    : '0;
  assign mem_wdata_o = w_mem_req ? w_sel_wdata : '0;
  assign oob_o       = w_any_gnt & ~w_dec.in_range;

  // One response pipe per port. Only one port is granted per cycle, so the
  // shared SRAM read data is consumed by at most one pipe at a time.
  udma_l2_resp_pipe #(
    .DW      (L2_DATA_WIDTH),
    .LATENCY (LATENCY)
  ) u_ro_pipe (
    .i_clk       (sys_clk_i),
    .i_rst_n     (sys_rst_ni),
    .i_valid     (w_ro_gnt),
    .i_in_range  (w_dec.in_range),
    .i_is_read   (ro.wen),
    .i_mem_rdata (mem_rdata_i),
    .o_rvalid    (ro.rvalid),
    .o_rdata     (ro.rdata)
  );

  udma_l2_resp_pipe #(
    .DW      (L2_DATA_WIDTH),
    .LATENCY (LATENCY)
  ) u_wo_pipe (
    .i_clk       (sys_clk_i),
    .i_rst_n     (sys_rst_ni),
    .i_valid     (w_wo_gnt),
    .i_in_range  (w_dec.in_range),
    .i_is_read   (wo.wen),
    .i_mem_rdata (mem_rdata_i),
    .o_rvalid    (wo.rvalid),
    .o_rdata     (wo.rdata)
  );

endmodule

// File: tb/tb_udma_l2_responder.sv
// -----------------------------------------------------------------------------
// tb_udma_l2_responder
// Directed bench for udma_l2_responder. dut_a runs with LATENCY=1 and dut_b
// with LATENCY=3; each has its own behavioural word SRAM with registered read
// and byte-enabled write. Inputs change on the falling edge; combinational
// outputs are sampled 1 time unit later and registered outputs 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_udma_l2_responder;
  import udma_l2_resp_pkg::*;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udma_l2_resp_if #(.DW(32)) ro_a ();
  udma_l2_resp_if #(.DW(32)) wo_a ();
  udma_l2_resp_if #(.DW(32)) ro_b ();
  udma_l2_resp_if #(.DW(32)) wo_b ();

  logic        mem_req_a, mem_we_a, oob_a;
  logic [14:0] mem_addr_a;
  logic [3:0]  mem_be_a;
  logic [31:0] mem_wdata_a;
  logic [31:0] mem_rdata_a = '0;
  logic        mem_req_b, mem_we_b, oob_b;
  logic [14:0] mem_addr_b;
  logic [3:0]  mem_be_b;
  logic [31:0] mem_wdata_b;
  logic [31:0] mem_rdata_b = '0;

  udma_l2_responder #(
    .L2_DATA_WIDTH(32), .MEM_ADDR_WIDTH(15), .BASE_ADDR(BASE), .LATENCY(1)
  ) dut_a (
    .sys_clk_i(clk), .sys_rst_ni(rst_n), .ro(ro_a), .wo(wo_a),
    .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
    .mem_be_o(mem_be_a), .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a),
    .oob_o(oob_a)
  );

  udma_l2_responder #(
    .L2_DATA_WIDTH(32), .MEM_ADDR_WIDTH(15), .BASE_ADDR(BASE), .LATENCY(3)
  ) dut_b (
    .sys_clk_i(clk), .sys_rst_ni(rst_n), .ro(ro_b), .wo(wo_b),
    .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
    .mem_be_o(mem_be_b), .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b),
    .oob_o(oob_b)
  );

  // Behavioural SRAMs (64 words, indexed by the low word-address bits),
  // preloaded on the first clock edge while reset is still held.
  logic [31:0] sram_a [64];
  logic [31:0] sram_b [64];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      init_done  <= 1'b1;
      sram_a[2]  <= 32'h1234_5678;
      sram_a[3]  <= 32'h1111_2222;
      sram_a[4]  <= 32'hA5A5_0001;
      sram_a[63] <= 32'h7FFF_7FFF;
      for (int i = 0; i < 4; i++) begin
        sram_a[16+i] <= 32'hC0DE_0010 + i;
        sram_b[i]    <= 32'hB0B0_0000 + i;
      end
    end else begin
      if (mem_req_a) begin
        if (mem_we_a) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_a[b]) sram_a[mem_addr_a[5:0]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
        end else begin
          mem_rdata_a <= sram_a[mem_addr_a[5:0]];
        end
      end
      if (mem_req_b) begin
        if (mem_we_b) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_b[b]) sram_b[mem_addr_b[5:0]][8*b +: 8] <= mem_wdata_b[8*b +: 8];
        end else begin
          mem_rdata_b <= sram_b[mem_addr_b[5:0]];
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ro_a(input logic req, input logic wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    ro_a.req = req; ro_a.wen = wen; ro_a.addr = addr; ro_a.be = be; ro_a.wdata = wdata;
  endtask

  task automatic set_wo_a(input logic req, input logic wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    wo_a.req = req; wo_a.wen = wen; wo_a.addr = addr; wo_a.be = be; wo_a.wdata = wdata;
  endtask

  task automatic set_ro_b(input logic req, input logic [31:0] addr);
    ro_b.req = req; ro_b.wen = 1'b1; ro_b.addr = addr; ro_b.be = 4'hF; ro_b.wdata = '0;
  endtask

  int ro_i;
  int wo_i;
  int ro_rv;
  int wo_rv;

  initial begin
    set_ro_a(0, 1, BASE, 4'hF, 0);
    set_wo_a(0, 0, BASE, 4'hF, 0);
    set_ro_b(0, BASE);
    wo_b.req = 1'b0; wo_b.wen = 1'b0; wo_b.addr = BASE; wo_b.be = 4'hF; wo_b.wdata = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    set_ro_a(1, 1, BASE, 4'hF, 0);
    #1;
    chk("rst_ro_gnt", {31'd0, ro_a.gnt}, 32'd0);
    chk("rst_ro_rvalid", {31'd0, ro_a.rvalid}, 32'd0);
    chk("rst_ro_rdata", ro_a.rdata, 32'd0);
    chk("rst_wo_rvalid", {31'd0, wo_a.rvalid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_a}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr_a}, 32'd0);
    chk("rst_mem_wdata", mem_wdata_a, 32'd0);
    chk("rst_oob", {31'd0, oob_a}, 32'd0);
    set_ro_a(0, 1, BASE, 4'hF, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // ---------------- single read, LATENCY=1 ----------------
    @(negedge clk);
    set_ro_a(1, 1, BASE + 32'h10, 4'hF, 0);
    #1;
    chk("rd_ro_gnt", {31'd0, ro_a.gnt}, 32'd1);
    chk("rd_wo_gnt", {31'd0, wo_a.gnt}, 32'd0);
    chk("rd_mem_req", {31'd0, mem_req_a}, 32'd1);
    chk("rd_mem_we", {31'd0, mem_we_a}, 32'd0);
    chk("rd_mem_addr", {17'd0, mem_addr_a}, 32'd4);
    @(posedge clk); #1;
    chk("rd_rvalid", {31'd0, ro_a.rvalid}, 32'd1);
    chk("rd_rdata", ro_a.rdata, 32'hA5A5_0001);
    $display("[TB] ro read word 4 -> %h", ro_a.rdata);
    @(negedge clk);
    set_ro_a(0, 1, BASE, 4'hF, 0);
    @(posedge clk); #1;
    chk("rd_rvalid_single", {31'd0, ro_a.rvalid}, 32'd0);

    // ---------------- 8 cycles of contention ----------------
    ro_i = 0; wo_i = 0; ro_rv = 0; wo_rv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_ro_a(1, 1, BASE + 32'h40 + 4*ro_i, 4'hF, 0);
      set_wo_a(1, 0, BASE + 32'h50 + 4*wo_i, 4'hF, 32'h5000_0000 + wo_i);
      #1;
      chk("cont_ro_gnt", {31'd0, ro_a.gnt}, {31'd0, (k % 2) == 0});
      chk("cont_wo_gnt", {31'd0, wo_a.gnt}, {31'd0, (k % 2) == 1});
      chk("cont_mem_req", {31'd0, mem_req_a}, 32'd1);
      @(posedge clk); #1;
      ro_rv += int'(ro_a.rvalid);
      wo_rv += int'(wo_a.rvalid);
      chk("cont_ro_rvalid", {31'd0, ro_a.rvalid}, {31'd0, (k % 2) == 0});
      chk("cont_wo_rvalid", {31'd0, wo_a.rvalid}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 0) begin
        chk("cont_ro_rdata", ro_a.rdata, 32'hC0DE_0010 + ro_i);
        $display("[TB] contention cycle %0d: ro rdata %h", k, ro_a.rdata);
        ro_i++;
      end else begin
        chk("cont_wo_rdata", wo_a.rdata, 32'd0);
        $display("[TB] contention cycle %0d: wo write ack", k);
        wo_i++;
      end
    end
    @(negedge clk);
    set_ro_a(0, 1, BASE, 4'hF, 0);
    set_wo_a(0, 0, BASE, 4'hF, 0);
    chk("cont_ro_count", ro_rv, 32'd4);
    chk("cont_wo_count", wo_rv, 32'd4);

    // ---------------- partial write then read back ----------------
    @(negedge clk);
    set_wo_a(1, 0, BASE + 32'h8, 4'b0011, 32'hDEAD_BEEF);
    #1;
    chk("wr_wo_gnt", {31'd0, wo_a.gnt}, 32'd1);
    chk("wr_mem_we", {31'd0, mem_we_a}, 32'd1);
    chk("wr_mem_addr", {17'd0, mem_addr_a}, 32'd2);
    chk("wr_mem_be", {28'd0, mem_be_a}, 32'h3);
    chk("wr_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("wr_rvalid", {31'd0, wo_a.rvalid}, 32'd1);
    chk("wr_rdata", wo_a.rdata, 32'd0);
    @(negedge clk);
    set_wo_a(0, 0, BASE, 4'hF, 0);
    set_ro_a(1, 1, BASE + 32'h8, 4'hF, 0);
    @(posedge clk); #1;
    chk("wr_readback", ro_a.rdata, 32'h1234_BEEF);
    $display("[TB] partial write readback %h", ro_a.rdata);

    // ---------------- same-word read and write in one cycle ----------------
    @(negedge clk);
    set_ro_a(1, 1, BASE + 32'hC, 4'hF, 0);
    set_wo_a(1, 0, BASE + 32'hC, 4'hF, 32'hAAAA_AAAA);
    #1;
    chk("rw_ro_first", {31'd0, ro_a.gnt}, 32'd1);
    chk("rw_wo_wait", {31'd0, wo_a.gnt}, 32'd0);
    @(posedge clk); #1;
    chk("rw_old_data", ro_a.rdata, 32'h1111_2222);
    @(negedge clk);
    set_ro_a(0, 1, BASE, 4'hF, 0);
    #1;
    chk("rw_wo_gnt", {31'd0, wo_a.gnt}, 32'd1);
    @(posedge clk); #1;
    chk("rw_wo_rvalid", {31'd0, wo_a.rvalid}, 32'd1);
    @(negedge clk);
    set_wo_a(0, 0, BASE, 4'hF, 0);
    set_ro_a(1, 1, BASE + 32'hC, 4'hF, 0);
    @(posedge clk); #1;
    chk("rw_new_data", ro_a.rdata, 32'hAAAA_AAAA);
    // The previous contention moved priority to wo.
    @(negedge clk);
    set_wo_a(1, 0, BASE + 32'h60, 4'hF, 32'h0);
    #1;
    chk("rr_wo_gnt", {31'd0, wo_a.gnt}, 32'd1);
    chk("rr_ro_gnt", {31'd0, ro_a.gnt}, 32'd0);
    @(negedge clk);
    set_wo_a(0, 0, BASE, 4'hF, 0);

    // ---------------- out-of-range and top-of-bank accesses ----------------
    set_ro_a(1, 1, BASE - 32'd4, 4'hF, 0);
    #1;
    chk("oob_lo_gnt", {31'd0, ro_a.gnt}, 32'd1);
    chk("oob_lo_mem_req", {31'd0, mem_req_a}, 32'd0);
    chk("oob_lo_pulse", {31'd0, oob_a}, 32'd1);
    @(posedge clk); #1;
    chk("oob_lo_rvalid", {31'd0, ro_a.rvalid}, 32'd1);
    chk("oob_lo_rdata", ro_a.rdata, 32'hBADA_CCE5);
    @(negedge clk);
    set_ro_a(1, 1, BASE + 32'h0002_0000, 4'hF, 0);
    #1;
    chk("oob_hi_mem_req", {31'd0, mem_req_a}, 32'd0);
    chk("oob_hi_pulse", {31'd0, oob_a}, 32'd1);
    @(posedge clk); #1;
    chk("oob_hi_rdata", ro_a.rdata, 32'hBADA_CCE5);
    @(negedge clk);
    set_ro_a(1, 1, BASE + 32'h0001_FFFC, 4'hF, 0);
    #1;
    chk("top_mem_req", {31'd0, mem_req_a}, 32'd1);
    chk("top_oob", {31'd0, oob_a}, 32'd0);
    chk("top_mem_addr", {17'd0, mem_addr_a}, 32'h7FFF);
    @(posedge clk); #1;
    chk("top_rdata", ro_a.rdata, 32'h7FFF_7FFF);
    @(negedge clk);
    set_ro_a(0, 1, BASE, 4'hF, 0);
    set_wo_a(1, 0, BASE - 32'd8, 4'hF, 32'h0001_2345);
    #1;
    chk("oob_wr_mem_req", {31'd0, mem_req_a}, 32'd0);
    chk("oob_wr_mem_we", {31'd0, mem_we_a}, 32'd0);
    chk("oob_wr_pulse", {31'd0, oob_a}, 32'd1);
    @(posedge clk); #1;
    chk("oob_wr_rvalid", {31'd0, wo_a.rvalid}, 32'd1);
    chk("oob_wr_rdata", wo_a.rdata, 32'd0);
    @(negedge clk);
    set_wo_a(0, 0, BASE, 4'hF, 0);
    #1;
    chk("oob_idle", {31'd0, oob_a}, 32'd0);

    // ---------------- LATENCY=3 back-to-back reads ----------------
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) set_ro_b(1, BASE + 4*c);
      else       set_ro_b(0, BASE);
      @(posedge clk); #1;
      chk("lat3_rvalid", {31'd0, ro_b.rvalid}, {31'd0, (c >= 2) && (c <= 5)});
      if ((c >= 2) && (c <= 5)) begin
        chk("lat3_rdata", ro_b.rdata, 32'hB0B0_0000 + (c - 2));
        $display("[TB] lat3 read word %0d -> %h", c - 2, ro_b.rdata);
      end
    end

    // ---------------- reset with responses in flight ----------------
    @(negedge clk);
    set_ro_b(1, BASE + 32'h8);
    @(negedge clk);
    set_ro_b(1, BASE + 32'hC);
    @(negedge clk);
    set_ro_b(0, BASE);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rstmid_rvalid", {31'd0, ro_b.rvalid}, 32'd0);
    end
    @(negedge clk);
    set_ro_b(1, BASE);
    #1;
    chk("rstmid_gnt", {31'd0, ro_b.gnt}, 32'd0);
    set_ro_b(0, BASE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid", {31'd0, ro_b.rvalid}, 32'd0);
    end
    @(negedge clk);
    set_ro_b(1, BASE + 32'h4);
    #1;
    chk("post_rst_gnt", {31'd0, ro_b.gnt}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_rv0", {31'd0, ro_b.rvalid}, 32'd0);
    @(negedge clk);
    set_ro_b(0, BASE);
    @(posedge clk); #1;
    chk("post_rst_rv1", {31'd0, ro_b.rvalid}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_rv2", {31'd0, ro_b.rvalid}, 32'd1);
    chk("post_rst_rdata", ro_b.rdata, 32'hB0B0_0001);
    $display("[TB] post-reset read -> %h", ro_b.rdata);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udma_l2_responder.md
# udma_l2_responder

Memory-side responder for the two uDMA L2 ports: the read-only port and the write-only port. It accepts transactions from both ports under the req/gnt/rvalid protocol. It arbitrates them onto a single-port word SRAM and returns responses after a fixed latency. It sits between `udma_subsystem` and an L2 SRAM bank in standalone IO test systems and FPGA bring-up builds.

## Interface
Parameters:
- `L2_DATA_WIDTH`, 32 (from `udma_pkg`): data width; byte enables are `L2_DATA_WIDTH/8`.
- `MEM_ADDR_WIDTH`, 15: SRAM word-address width; the bank covers `4*2^MEM_ADDR_WIDTH` bytes.
- `BASE_ADDR`, 32'h1C00_0000: byte address of SRAM word 0.
- `LATENCY`, 1: cycles from gnt to rvalid; legal range 1..4.

Ports:
- `sys_clk_i`  in  1  single clock.
- `sys_rst_ni`  in  1  reset; asynchronous, active-low.
- `ro_req_i` / `wo_req_i`  in  1  request.
- `ro_wen_i` / `wo_wen_i`  in  1  1 = read, 0 = write.
- `ro_addr_i` / `wo_addr_i`  in  32  byte address.
- `ro_be_i` / `wo_be_i`  in  L2_DATA_WIDTH/8  byte enables.
- `ro_wdata_i` / `wo_wdata_i`  in  L2_DATA_WIDTH  write data.
- `ro_gnt_o` / `wo_gnt_o`  out  1  grant; combinational from req.
- `ro_rvalid_o` / `wo_rvalid_o`  out  1  response valid.
- `ro_rdata_o` / `wo_rdata_o`  out  L2_DATA_WIDTH  read data.
- `mem_req_o`  out  1  SRAM access.
- `mem_we_o`  out  1  SRAM write, active-high.
- `mem_addr_o`  out  MEM_ADDR_WIDTH  SRAM word address.
- `mem_be_o`  out  L2_DATA_WIDTH/8  SRAM byte enables.
- `mem_wdata_o`  out  L2_DATA_WIDTH  SRAM write data.
- `mem_rdata_i`  in  L2_DATA_WIDTH  SRAM read data, valid 1 cycle after `mem_req_o`.
- `oob_o`  out  1  one-cycle pulse when an out-of-range access is granted.

## Operation
- At most one grant per cycle across both ports.
- A lone request is granted in the same cycle it is presented.
- Contention (both `req` high):
  - The port selected by round-robin pointer `rr_q` wins; `rr_q` resets to ro.
  - `rr_q` toggles to the other port only after a contended grant. Uncontended grants leave it unchanged.
- Address decode: `off = addr - BASE_ADDR`, 32-bit unsigned wrap.
  - In range iff `off < 4*2^MEM_ADDR_WIDTH`.
  - Word address = `off[MEM_ADDR_WIDTH+1:2]`; `addr[1:0]` are ignored.
- In-range grant: `mem_req_o=1`, `mem_we_o=~wen`, and be/wdata pass through combinationally.
- Out-of-range grant:
  - `mem_req_o=0` and `oob_o=1` in the grant cycle.
  - Read returns `OOB_RDATA` (32'hBADA_CCE5, replicated to fill the width).
  - Write is dropped.
- Every granted transaction, read or write, produces exactly one rvalid on its own port.
  - Write responses carry rdata = 0.
  - Responses on a port are returned in grant order; there is no backpressure on rvalid.
- Non-granted ports must hold their request (protocol rule). The responder does not latch a pending request.

## Timing
- Grant at cycle T → rvalid at T+LATENCY, one cycle wide.
- LATENCY=1: rdata = `mem_rdata_i`, muxed by registered flags (in-range, read).
- LATENCY>1: rdata passes through LATENCY-1 register stages.
- Throughput: one transaction per cycle aggregate, fully pipelined; a grant is possible every cycle.
- Reset values:
  - All rvalid, rdata, `oob_o`, `mem_req_o` and `mem_we_o` are 0; mem addr/be/wdata are 0 when `mem_req_o=0`.
  - gnt outputs are forced to 0 while `sys_rst_ni` is low.
- Reset mid-operation: pipelines clear immediately and in-flight responses are lost. The first grant after reset starts a fresh pipeline.
- Same-word read and write in the same cycle are serialized by the arbiter.
  - A read granted after the write sees the new data.
  - A read granted before the write sees the old data.
- rvalid on both ports in the same cycle is legal.

## Structure
- Package `udma_l2_resp_pkg` holds `OOB_RDATA`, the range-check/word-address function, and the `port_e {PORT_RO, PORT_WO}` enum for `rr_q`.
- Sub-module `udma_l2_resp_pipe`: per-port delay line of depth LATENCY carrying valid, in-range, is-read and rdata stages. It is instantiated twice; the top holds the arbiter and decode.

## Test plan
- ro read at BASE_ADDR+0x10 after SRAM word 4 preloaded with 0xA5A5_0001, LATENCY=1 → gnt same cycle, `mem_addr_o`=4, rvalid next cycle with rdata 0xA5A5_0001.
- ro and wo requests every cycle for 8 cycles → grants alternate starting ro (ro, wo, ro, …); `mem_req_o` high all 8 cycles; each port gets 4 rvalids in order.
- wo write 0xDEAD_BEEF, be=4'b0011, to BASE_ADDR+0x8, then ro read of the same address → read returns {old[31:16], 16'hBEEF}; the write rvalid carries rdata 0.
- ro read at BASE_ADDR-4 and at BASE_ADDR+4*2^15 → granted, `mem_req_o`=0, `oob_o` pulse, rdata 0xBADA_CCE5.
- LATENCY=3, back-to-back reads of words 0..3 → rvalids at T+3..T+6 with matching data.
- Reset asserted 1 cycle after 2 reads are granted → no rvalid appears; after release, a new read completes normally.
